canvas_pool: RTL and testbench

CANVAS_POOL -- requirements
Module: canvas_pool

---
 rtl/canvas_pkg.sv | 14 +
 rtl/canvas_pool_band.sv | 45 ++++
 rtl/canvas_pool.sv | 119 +++++++++++
 tb/tb_canvas_pool.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/canvas_pkg.sv
// Shared geometry constants and FSM state encoding for the canvas pooling block.
package canvas_pkg;
  localparam int CANVAS_DIM = 32;
  localparam int CANVAS_AW  = 10;
  localparam int CELL_DIM   = 4;
  localparam int GRID_DIM   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } pool_state_e;
endpackage

// File: rtl/canvas_pool_band.sv
// Eight saturating per-cell counters for the 4-row band currently being scanned,
// with threshold compare that already includes the pixel arriving this cycle.
module canvas_pool_band
  import canvas_pkg::*;
#(
  parameter int POOL_THRESH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                pix_vld,
  input  logic [2:0]          pix_cx,
  input  logic                pix_data,
  input  logic                flush,
  output logic [GRID_DIM-1:0] cell_hit
);

  localparam logic [4:0] THRESH  = 5'(POOL_THRESH);
  localparam logic [4:0] CNT_MAX = 5'(CELL_DIM * CELL_DIM);

  logic [4:0] cnt_q [GRID_DIM];
  logic [4:0] cnt_d [GRID_DIM];

  // hit is taken from the updated count so the band's last pixel is included
  always_comb begin
    cell_hit = '0;
    for (int i = 0; i < GRID_DIM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (pix_vld && pix_data && (pix_cx == 3'(i)) && (cnt_q[i] < CNT_MAX))
        cnt_d[i] = cnt_q[i] + 5'd1;
      cell_hit[i] = (cnt_d[i] >= THRESH);
      if (clear || flush)
        cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GRID_DIM; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < GRID_DIM; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: rtl/canvas_pool.sv
// Scans the 32x32 canvas RAM once per start and pools it into an 8x8 feature grid,
// holding the result until the consumer accepts it.
module canvas_pool
  import canvas_pkg::*;
#(
  parameter int POOL_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [8:0]           block_pos,
  output logic                 rd_en,
  output logic [CANVAS_AW-1:0] rd_addr,
  input  logic                 rd_data,
  output logic [63:0]          feat,
  output logic [8:0]           feat_pos,
  output logic [10:0]          pix_count,
  output logic                 empty,
  output logic                 feat_valid,
  input  logic                 feat_ready,
  output logic                 busy
);

  pool_state_e          state_q, state_d;
  logic [CANVAS_AW-1:0] addr_q, addr_d;
  logic [CANVAS_AW-1:0] paddr_q, paddr_d;
  logic                 pvld_q, pvld_d;
  logic [8:0]           pos_q, pos_d;
  logic [63:0]          feat_q, feat_d;
  logic [10:0]          cnt_q, cnt_d;
  logic                 clear;
  logic                 band_flush;
  logic [GRID_DIM-1:0]  cell_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (addr_q == CANVAS_AW'(CANVAS_DIM * CANVAS_DIM - 1)) state_d = DRAIN;
      DRAIN:   state_d = HOLD;
      HOLD:    if (feat_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en      = (state_q == SCAN);
    busy       = (state_q != IDLE);
    feat_valid = (state_q == HOLD);
    empty      = feat_valid && (cnt_q == '0);
    rd_addr    = addr_q;
    feat       = feat_q;
    feat_pos   = pos_q;
    pix_count  = cnt_q;
  end

  // RAM data lags the address by one cycle, so its address rides along in paddr
  assign band_flush = pvld_q && (paddr_q[6:5] == 2'b11) && (paddr_q[4:0] == 5'd31);

  always_comb begin
    addr_d  = addr_q;
    pos_d   = pos_q;
    feat_d  = feat_q;
    cnt_d   = cnt_q;
    clear   = 1'b0;
    pvld_d  = rd_en;
    paddr_d = addr_q;
    if (state_q == IDLE && start) begin
      addr_d = '0;
      pos_d  = block_pos;
      feat_d = '0;
      cnt_d  = '0;
      clear  = 1'b1;
    end else if (state_q == SCAN) begin
      addr_d = addr_q + 1'b1;
    end
    if (pvld_q && rd_data && (cnt_q < 11'd1024))
      cnt_d = cnt_q + 11'd1;
    if (band_flush) begin
      for (int cx = 0; cx < GRID_DIM; cx++)
        feat_d[{paddr_q[9:7], 3'(cx)}] = cell_hit[cx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      paddr_q <= '0;
      pvld_q  <= 1'b0;
      pos_q   <= '0;
      feat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      paddr_q <= paddr_d;
      pvld_q  <= pvld_d;
      pos_q   <= pos_d;
      feat_q  <= feat_d;
      cnt_q   <= cnt_d;
    end
  end

  canvas_pool_band #(.POOL_THRESH(POOL_THRESH)) u_band (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .pix_vld  (pvld_q),
    .pix_cx   (paddr_q[4:2]),
    .pix_data (rd_data),
    .flush    (band_flush),
    .cell_hit (cell_hit)
  );

endmodule

// File: tb/tb_canvas_pool.sv
// Self-checking bench for canvas_pool: two instances (threshold 1 and 2) read one
// behavioural canvas RAM; expected results are queued at start and popped at feat_valid.
module tb_canvas_pool;

  typedef struct {
    logic [63:0] f1;
    logic [63:0] f2;
    logic [10:0] cnt;
    logic [8:0]  pos;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  block_pos = '0;
  logic        feat_ready = 1'b0;

  logic        rd_en1, rd_en2;
  logic [9:0]  rd_addr1, rd_addr2;
  logic        rd_data1 = 1'b0, rd_data2 = 1'b0;
  logic [63:0] feat1, feat2;
  logic [8:0]  feat_pos1, feat_pos2;
  logic [10:0] pix_count1, pix_count2;
  logic        empty1, empty2, feat_valid1, feat_valid2, busy1, busy2;

  logic        mem [1024];
  exp_t        sb [$];

  int tests_run = 0;
  int tests_failed = 0;

  int exp_addr = 0;
  int run_len = 0;
  int last_run_len = 0;
  int addr_err = 0;
  logic rd_en_prev = 1'b0;

  always #5 clk = ~clk;

  canvas_pool #(.POOL_THRESH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .block_pos(block_pos),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .feat(feat1), .feat_pos(feat_pos1), .pix_count(pix_count1), .empty(empty1),
    .feat_valid(feat_valid1), .feat_ready(feat_ready), .busy(busy1)
  );

  canvas_pool #(.POOL_THRESH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .block_pos(block_pos),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .feat(feat2), .feat_pos(feat_pos2), .pix_count(pix_count2), .empty(empty2),
    .feat_valid(feat_valid2), .feat_ready(feat_ready), .busy(busy2)
  );

  always @(posedge clk) begin
    if (rd_en1) rd_data1 <= mem[rd_addr1];
    if (rd_en2) rd_data2 <= mem[rd_addr2];
  end

  // Read-stream monitor: contiguity errors and length of each rd_en run
  always @(negedge clk) begin
    if (rd_en1) begin
      if (!rd_en_prev) begin
        exp_addr = 0;
        run_len = 0;
      end
      if (rd_addr1 !== 10'(exp_addr)) addr_err++;
      exp_addr++;
      run_len++;
    end else if (rd_en_prev) begin
      last_run_len = run_len;
    end
    rd_en_prev = rd_en1;
  end

  task automatic fill_mem(input int mode);
    for (int a = 0; a < 1024; a++) begin
      case (mode)
        0: mem[a] = 1'b0;
        1: mem[a] = 1'b1;
        2: mem[a] = (a == 10'h0A9);
        3: mem[a] = ((a[9:7] == 3'd0) && (a[6:5] <= 2'd3) && (a[4:2] == 3'd0));
        default: mem[a] = 1'($urandom_range(0, 7) == 0);
      endcase
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests_run++;
    if ({rd_en1, rd_addr1, feat1, feat_pos1, pix_count1, empty1, feat_valid1, busy1} !== '0 ||
        {rd_en2, rd_addr2, feat2, feat_pos2, pix_count2, empty2, feat_valid2, busy2} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL %s: got rd_en=%b addr=%h feat=%h pos=%h cnt=%0d empty=%b valid=%b busy=%b, required all zero",
               name, rd_en1, rd_addr1, feat1, feat_pos1, pix_count1, empty1, feat_valid1, busy1);
    end
  endtask

  task automatic do_pass(input logic [8:0] pos, input int stall, input bit poke, input bit ready_early);
    exp_t e;
    exp_t g;
    int   cyc;
    int   err0;
    e.f1 = '0; e.f2 = '0; e.cnt = '0; e.pos = pos;
    for (int cy = 0; cy < 8; cy++) begin
      for (int cx = 0; cx < 8; cx++) begin
        int n;
        n = 0;
        for (int dy = 0; dy < 4; dy++)
          for (int dx = 0; dx < 4; dx++)
            if (mem[(cy * 4 + dy) * 32 + cx * 4 + dx]) n++;
        e.f1[cy * 8 + cx] = (n >= 1);
        e.f2[cy * 8 + cx] = (n >= 2);
        e.cnt = e.cnt + 11'(n);
      end
    end
    sb.push_back(e);
    err0 = addr_err;

    @(negedge clk);
    block_pos  = pos;
    start      = 1'b1;
    feat_ready = ready_early;
    @(posedge clk);
    #1;
    start     = 1'b0;
    block_pos = 9'($urandom);
    cyc = 0;
    while (cyc < 1100 && !feat_valid1) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    tests_run++;
    if (cyc != 1025) begin
      tests_failed++;
      $display("[TB] FAIL latency: got %0d cycles, required 1025", cyc);
    end

    g = sb.pop_front();
    tests_run++;
    if (feat1 !== g.f1) begin
      tests_failed++;
      $display("[TB] FAIL feat_t1: got %h required %h", feat1, g.f1);
    end
    tests_run++;
    if (feat2 !== g.f2) begin
      tests_failed++;
      $display("[TB] FAIL feat_t2: got %h required %h", feat2, g.f2);
    end
    tests_run++;
    if (pix_count1 !== g.cnt || pix_count2 !== g.cnt) begin
      tests_failed++;
      $display("[TB] FAIL pix_count: got %0d/%0d required %0d", pix_count1, pix_count2, g.cnt);
    end
    tests_run++;
    if (empty1 !== (g.cnt == 0) || empty2 !== (g.cnt == 0)) begin
      tests_failed++;
      $display("[TB] FAIL empty: got %b/%b required %b", empty1, empty2, (g.cnt == 0));
    end
    tests_run++;
    if (feat_pos1 !== g.pos || feat_pos2 !== g.pos) begin
      tests_failed++;
      $display("[TB] FAIL feat_pos: got %h/%h required %h", feat_pos1, feat_pos2, g.pos);
    end
    tests_run++;
    if (feat_valid2 !== 1'b1 || busy1 !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL valid_busy: got valid2=%b busy1=%b required 1/1", feat_valid2, busy1);
    end
    tests_run++;
    if (last_run_len != 1024) begin
      tests_failed++;
      $display("[TB] FAIL rd_en_len: got %0d required 1024", last_run_len);
    end
    tests_run++;
    if (addr_err != err0) begin
      tests_failed++;
      $display("[TB] FAIL rd_addr_contig: got %0d gaps required 0", addr_err - err0);
    end

    for (int i = 0; i < stall; i++) begin
      if (i == 5) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      tests_run++;
      if ({feat1, feat_pos1, pix_count1, empty1, feat_valid1, busy1} !==
          {g.f1, g.pos, g.cnt, (g.cnt == 11'd0), 1'b1, 1'b1}) begin
        tests_failed++;
        $display("[TB] FAIL hold_stable: cycle %0d got feat=%h pos=%h cnt=%0d valid=%b busy=%b required feat=%h pos=%h cnt=%0d valid=1 busy=1",
                 i, feat1, feat_pos1, pix_count1, feat_valid1, busy1, g.f1, g.pos, g.cnt);
      end
    end

    feat_ready = 1'b1;
    start      = poke;
    @(posedge clk);
    #1;
    feat_ready = 1'b0;
    start      = 1'b0;
    tests_run++;
    if ({busy1, busy2, feat_valid1, feat_valid2} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL accept: got busy=%b%b valid=%b%b required 0000", busy1, busy2, feat_valid1, feat_valid2);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({busy1, rd_en1} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_accept: got busy=%b rd_en=%b required 0/0", busy1, rd_en1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_state");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_all_zero();
    fill_mem(0);
    do_pass(9'h1A5, 0, 1'b0, 1'b0);
  endtask

  task automatic test_all_one();
    fill_mem(1);
    do_pass(9'h0FF, 0, 1'b0, 1'b0);
  endtask

  task automatic test_single_pixel();
    fill_mem(2);
    do_pass(9'h0A9, 0, 1'b0, 1'b0);
  endtask

  task automatic test_hold_stall();
    fill_mem(4);
    do_pass(9'h133, 20, 1'b1, 1'b0);
  endtask

  task automatic test_reset_abort();
    int cyc;
    fill_mem(1);
    @(negedge clk);
    start = 1'b1;
    block_pos = 9'h055;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 700 && !(rd_en1 && rd_addr1 == 10'd500)) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    tests_run++;
    if (!(rd_en1 && rd_addr1 == 10'd500)) begin
      tests_failed++;
      $display("[TB] FAIL reach_addr_500: got rd_en=%b addr=%0d required 1/500", rd_en1, rd_addr1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_abort");
    @(negedge clk);
    rst_n = 1'b1;
    fill_mem(3);
    do_pass(9'h1C0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      fill_mem(4);
      do_pass(9'($urandom), 0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_all_one();
    test_single_pixel();
    test_hold_stall();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
